// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants for frame layout, line levels and default baud divisor
package uart_pkg;
  localparam int UART_DIVISOR_DEFAULT = 434;
  localparam int UART_FRAME_BITS = 10;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT = 1'b1;
  localparam logic UART_IDLE = 1'b1;
  typedef logic [UART_FRAME_BITS-1:0] frame_t;
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: one-shot bit-period timer; load restarts it, co pulses once DIVISOR-1 cycles after load (clk, reset, load in; co out)
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int DIVISOR = UART_DIVISOR_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic co
);
  localparam int W = $clog2(DIVISOR);
  localparam logic [W-1:0] RELOAD = W'(DIVISOR - 2);
  logic [W-1:0] count_q, count_d;
  logic run_q, run_d;
  assign co = run_q && count_q == '0;
  always_comb begin
    count_d = load ? RELOAD : (run_q && count_q != '0) ? count_q - 1'b1 : count_q;
    run_d = load | (run_q & ~co);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      run_q <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/uart_tx_datapath.sv
// uart_tx_datapath: UART transmit buffer, baud timer and frame shifter (host wr_en/wr_data/ovr_clr in, tbr_ready/overrun out; FSM strobes in, tbr_valid/co out; txd serial out)
module uart_tx_datapath
  import uart_pkg::*;
#(
  parameter int DIVISOR = UART_DIVISOR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ovr_clr,
  input  logic       clear_valid,
  input  logic       shift,
  input  logic       load_sr,
  input  logic       set_sr,
  input  logic       load_counter,
  output logic       tbr_valid,
  output logic       tbr_ready,
  output logic       co,
  output logic       overrun,
  output logic       txd
);
  logic [7:0] tbr_q, tbr_d;
  logic tbr_valid_q, tbr_valid_d, overrun_q, overrun_d, accept;
  frame_t sr_q, sr_d;
  assign tbr_ready = ~tbr_valid_q | clear_valid;
  assign accept = wr_en & tbr_ready;
  assign tbr_valid = tbr_valid_q;
  assign overrun = overrun_q;
  assign txd = sr_q[0];
  always_comb begin
    tbr_d = accept ? wr_data : tbr_q;
    tbr_valid_d = accept ? 1'b1 : clear_valid ? 1'b0 : tbr_valid_q;
    overrun_d = (wr_en & ~tbr_ready) ? 1'b1 : ovr_clr ? 1'b0 : overrun_q;
    sr_d = load_sr ? {UART_STOP_BIT, tbr_q, UART_START_BIT}
         : set_sr  ? {UART_FRAME_BITS{UART_IDLE}}
         : shift   ? {UART_IDLE, sr_q[UART_FRAME_BITS-1:1]}
         : sr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tbr_q <= '0;
      tbr_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      sr_q <= {UART_FRAME_BITS{UART_IDLE}};
    end else begin
      tbr_q <= tbr_d;
      tbr_valid_q <= tbr_valid_d;
      overrun_q <= overrun_d;
      sr_q <= sr_d;
    end
  end
  uart_baud_counter #(.DIVISOR(DIVISOR)) u_baud (
    .clk  (clk),
    .reset(reset),
    .load (load_counter),
    .co   (co)
  );
endmodule

// File: tb/tb_uart_tx_datapath.sv
// tb_uart_tx_datapath: directed checks of the UART transmit datapath with the bench acting as control FSM
module tb_uart_tx_datapath;
  localparam int D = 4;
  logic clk, reset, wr_en, ovr_clr, clear_valid, shift, load_sr, set_sr, load_counter, lc2;
  logic [7:0] wr_data;
  logic tbr_valid, tbr_ready, co, overrun, txd;
  logic tbr_valid2, tbr_ready2, co2, overrun2, txd2;
  int checks, errors;

  uart_tx_datapath #(.DIVISOR(D)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .ovr_clr(ovr_clr),
    .clear_valid(clear_valid), .shift(shift), .load_sr(load_sr), .set_sr(set_sr),
    .load_counter(load_counter), .tbr_valid(tbr_valid), .tbr_ready(tbr_ready),
    .co(co), .overrun(overrun), .txd(txd)
  );

  uart_tx_datapath #(.DIVISOR(2)) dut2 (
    .clk(clk), .reset(reset), .wr_en(1'b0), .wr_data(8'h00), .ovr_clr(1'b0),
    .clear_valid(1'b0), .shift(1'b0), .load_sr(1'b0), .set_sr(1'b0),
    .load_counter(lc2), .tbr_valid(tbr_valid2), .tbr_ready(tbr_ready2),
    .co(co2), .overrun(overrun2), .txd(txd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic write(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic start(input logic w, input logic [7:0] d);
    load_sr = 1'b1;
    clear_valid = 1'b1;
    load_counter = 1'b1;
    wr_en = w;
    wr_data = d;
    #1;
    chk("start_ready", tbr_ready, 1);
    cyc();
    load_sr = 1'b0;
    clear_valid = 1'b0;
    load_counter = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic bits(input logic [7:0] b, input bit chain, input int stop_i);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < D; k++) begin
        if (i == stop_i && k == 1) return;
        chk($sformatf("txd %02h b%0d c%0d", b, i, k), txd, f[i]);
        chk($sformatf("co %02h b%0d c%0d", b, i, k), co, k == D - 2);
        if (k < D - 1) cyc();
        else if (i < 9) begin
          shift = 1'b1;
          load_counter = 1'b1;
          cyc();
          shift = 1'b0;
          load_counter = 1'b0;
        end else if (chain) start(1'b0, 8'h00);
        else begin
          set_sr = 1'b1;
          cyc();
          set_sr = 1'b0;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    {wr_en, ovr_clr, clear_valid, shift, load_sr, set_sr, load_counter, lc2} = '0;
    wr_data = 8'h00;
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_txd", txd, 1);
    chk("rst_valid", tbr_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_co", co, 0);
    chk("rst_ready", tbr_ready, 1);
    chk("rst_co2", co2, 0);

    load_counter = 1'b1;
    cyc();
    load_counter = 1'b0;
    chk("baud_l1", co, 0);
    cyc();
    chk("baud_l2", co, 0);
    cyc();
    chk("baud_l3", co, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("baud_quiet%0d", i), co, 0);
    end
    load_counter = 1'b1;
    cyc();
    load_counter = 1'b0;
    chk("reload_l1", co, 0);
    cyc();
    chk("reload_l2", co, 0);
    load_counter = 1'b1;
    cyc();
    load_counter = 1'b0;
    chk("reload_l3", co, 0);
    cyc();
    chk("reload_l4", co, 0);
    cyc();
    chk("reload_l5", co, 1);
    cyc();
    chk("reload_l6", co, 0);

    lc2 = 1'b1;
    cyc();
    lc2 = 1'b0;
    chk("div2_l1", co2, 1);
    cyc();
    chk("div2_l2", co2, 0);
    cyc();
    chk("div2_l3", co2, 0);

    wr_en = 1'b1;
    wr_data = 8'hA5;
    #1;
    chk("wr_ready", tbr_ready, 1);
    cyc();
    wr_en = 1'b0;
    chk("wr_valid", tbr_valid, 1);
    start(1'b0, 8'h00);
    chk("frame_cleared", tbr_valid, 0);
    bits(8'hA5, 1'b0, 10);
    for (int i = 0; i < 3; i++) begin
      chk("idle_txd", txd, 1);
      chk("idle_co", co, 0);
      cyc();
    end

    write(8'h11);
    chk("ovr_ready", tbr_ready, 0);
    write(8'h22);
    chk("ovr_set", overrun, 1);
    chk("ovr_valid", tbr_valid, 1);
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    ovr_clr = 1'b1;
    write(8'h33);
    ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    ovr_clr = 1'b1;
    cyc();
    ovr_clr = 1'b0;
    chk("ovr_clr2", overrun, 0);
    start(1'b0, 8'h00);
    bits(8'h11, 1'b0, 10);

    write(8'hC3);
    start(1'b1, 8'h3C);
    chk("b2b_valid", tbr_valid, 1);
    bits(8'hC3, 1'b1, 10);
    bits(8'h3C, 1'b0, 10);
    chk("b2b_done_valid", tbr_valid, 0);
    chk("b2b_done_txd", txd, 1);

    write(8'hA5);
    start(1'b1, 8'h77);
    bits(8'hA5, 1'b0, 5);
    reset = 1'b1;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_valid", tbr_valid, 0);
    chk("mid_rst_co", co, 0);
    reset = 1'b0;
    cyc();
    write(8'h5A);
    start(1'b0, 8'h00);
    bits(8'h5A, 1'b0, 10);

    write(8'h00);
    load_sr = 1'b1;
    clear_valid = 1'b1;
    cyc();
    load_sr = 1'b0;
    clear_valid = 1'b0;
    chk("pri_start", txd, 0);
    chk("pri_clear_valid", tbr_valid, 0);
    shift = 1'b1;
    cyc();
    chk("pri_b0", txd, 0);
    set_sr = 1'b1;
    cyc();
    set_sr = 1'b0;
    chk("pri_set_over_shift", txd, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("pri_ones%0d", i), txd, 1);
    end
    shift = 1'b0;
    load_sr = 1'b1;
    set_sr = 1'b1;
    cyc();
    load_sr = 1'b0;
    set_sr = 1'b0;
    chk("pri_load_over_set", txd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
